// File: rtl/convolution_processor_pkg.sv
// Shared types and default widths for the convolution processor.
package convolution_processor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } conv_state_e;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_X_W_DEF = 5;
    localparam int ADDR_Y_W_DEF = 5;
    localparam int ADDR_Z_W_DEF = 6;

endpackage

// File: rtl/convolution_processor_if.sv
// Control, ROM read and result write bus of the convolution core.
interface convolution_processor_if
    import convolution_processor_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int ADDR_X_WIDTH = ADDR_X_W_DEF,
    parameter int ADDR_Y_WIDTH = ADDR_Y_W_DEF,
    parameter int ADDR_Z_WIDTH = ADDR_Z_W_DEF,
    parameter int ACC_WIDTH    = 2*DATA_WIDTH +
                                 ((ADDR_X_WIDTH < ADDR_Y_WIDTH) ? ADDR_X_WIDTH : ADDR_Y_WIDTH)
);
    logic                    start_i;
    logic [ADDR_X_WIDTH:0]   size_x_i;
    logic [ADDR_Y_WIDTH:0]   size_y_i;
    logic [ADDR_X_WIDTH-1:0] mem_x_addr_o;
    logic [DATA_WIDTH-1:0]   mem_x_data_i;
    logic [ADDR_Y_WIDTH-1:0] mem_y_addr_o;
    logic [DATA_WIDTH-1:0]   mem_y_data_i;
    logic [ADDR_Z_WIDTH-1:0] mem_z_addr_o;
    logic [ACC_WIDTH-1:0]    mem_z_data_o;
    logic                    mem_z_we_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        input  start_i, size_x_i, size_y_i, mem_x_data_i, mem_y_data_i,
        output mem_x_addr_o, mem_y_addr_o, mem_z_addr_o, mem_z_data_o,
               mem_z_we_o, busy_o, done_o
    );

    modport slave (
        output start_i, size_x_i, size_y_i, mem_x_data_i, mem_y_data_i,
        input  mem_x_addr_o, mem_y_addr_o, mem_z_addr_o, mem_z_data_o,
               mem_z_we_o, busy_o, done_o
    );

endinterface

// File: rtl/convolution_processor_mac.sv
// Multiply-accumulate stage: valid/first are delayed one cycle to line up
// with the registered ROM data, then the product clears or adds into acc.
module convolution_processor_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);
    logic                    vld_q;
    logic                    first_q;
    logic [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc     <= '0;
        end else begin
            vld_q   <= valid;
            first_q <= first;
            if (vld_q)
                acc <= first_q ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/convolution_processor_core.sv
// Sequencer for full linear convolution Z[k] = sum X[i]*Y[k-i]; walks the
// X/Y ROMs one term per cycle and writes each Z[k] once.
module convolution_processor_core
    import convolution_processor_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int ADDR_X_WIDTH = ADDR_X_W_DEF,
    parameter int ADDR_Y_WIDTH = ADDR_Y_W_DEF,
    parameter int ADDR_Z_WIDTH = ADDR_Z_W_DEF,
    parameter int ACC_WIDTH    = 2*DATA_WIDTH +
                                 ((ADDR_X_WIDTH < ADDR_Y_WIDTH) ? ADDR_X_WIDTH : ADDR_Y_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    convolution_processor_if.master bus
);
    localparam int            KW    = ADDR_Z_WIDTH + 1;
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [KW-1:0] K_TWO = KW'(2);

    conv_state_e             state, state_nx;
    logic [ADDR_X_WIDTH:0]   sx;
    logic [ADDR_Y_WIDTH:0]   sy;
    logic [KW-1:0]           k, k_nx, last_k, i_cur, i_lo, i_hi, i_lo_nx, sx_m1;
    logic [ADDR_X_WIDTH-1:0] x_addr;
    logic [ADDR_Y_WIDTH-1:0] y_addr;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    last_i, last_k_hit, zero_size, mac_valid, mac_first;

    // First X index contributing to Z[kk]: max(0, kk - size_y + 1).
    function automatic logic [KW-1:0] lo_of(input logic [KW-1:0] kk, input logic [KW-1:0] szy);
        return (kk + K_ONE > szy) ? kk + K_ONE - szy : '0;
    endfunction

    assign i_cur      = KW'(x_addr);
    assign sx_m1      = KW'(sx) - K_ONE;
    assign i_lo       = lo_of(k, KW'(sy));
    assign i_hi       = (k < sx_m1) ? k : sx_m1;
    assign k_nx       = k + K_ONE;
    assign i_lo_nx    = lo_of(k_nx, KW'(sy));
    assign last_k     = KW'(sx) + KW'(sy) - K_TWO;
    assign last_i     = (i_cur == i_hi);
    assign last_k_hit = (k == last_k);
    assign zero_size  = (bus.size_x_i == '0) || (bus.size_y_i == '0);
    assign mac_valid  = (state == FETCH);
    assign mac_first  = (i_cur == i_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start_i) state_nx = zero_size ? DONE : FETCH;
            FETCH:   if (last_i) state_nx = DRAIN;
            DRAIN:   state_nx = WRITE;
            WRITE:   state_nx = last_k_hit ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The address registers double as the i / k-i counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx     <= '0;
            sy     <= '0;
            k      <= '0;
            x_addr <= '0;
            y_addr <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    sx     <= bus.size_x_i;
                    sy     <= bus.size_y_i;
                    k      <= '0;
                    x_addr <= '0;
                    y_addr <= '0;
                end
                FETCH: if (!last_i) begin
                    x_addr <= x_addr + ADDR_X_WIDTH'(1);
                    y_addr <= y_addr - ADDR_Y_WIDTH'(1);
                end
                WRITE: if (!last_k_hit) begin
                    k      <= k_nx;
                    x_addr <= ADDR_X_WIDTH'(i_lo_nx);
                    y_addr <= ADDR_Y_WIDTH'(k_nx - i_lo_nx);
                end
                default: ;
            endcase
        end
    end

    convolution_processor_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (mac_valid),
        .first (mac_first),
        .a     (bus.mem_x_data_i),
        .b     (bus.mem_y_data_i),
        .acc   (acc)
    );

    assign bus.mem_x_addr_o = x_addr;
    assign bus.mem_y_addr_o = y_addr;

    always_comb begin
        bus.mem_z_we_o   = (state == WRITE);
        bus.mem_z_addr_o = (state == WRITE) ? ADDR_Z_WIDTH'(k) : '0;
        bus.mem_z_data_o = (state == WRITE) ? acc : '0;
        bus.busy_o       = (state == FETCH) || (state == DRAIN) || (state == WRITE);
        bus.done_o       = (state == DONE);
    end

endmodule

// File: tb/tb_convolution_processor_core.sv
// Directed bench: table of small convolutions plus hand-written sequences
// for full-size, mid-run reset and back-to-back starts.
module tb_convolution_processor_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    convolution_processor_if bus ();

    convolution_processor_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] xrom [32];
    logic [7:0] yrom [32];
    int         exp_z [64];
    int         n_chk  = 0;
    int         n_fail = 0;

    // Synchronous-read ROMs, one cycle of latency.
    always @(posedge clk) begin
        bus.mem_x_data_i <= xrom[bus.mem_x_addr_o];
        bus.mem_y_data_i <= yrom[bus.mem_y_addr_o];
    end

    typedef struct packed {
        int               sx;
        int               sy;
        int               nw;
        int               nbusy;
        logic [0:3][7:0]  x;
        logic [0:3][7:0]  y;
        logic [0:6][20:0] z;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 32; i++) begin
            xrom[i] = 8'h5A;
            yrom[i] = 8'hC3;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < vecs[v].sx) xrom[i] = vecs[v].x[i];
            if (i < vecs[v].sy) yrom[i] = vecs[v].y[i];
        end
        for (int j = 0; j < 64; j++) exp_z[j] = (j < 7) ? int'(vecs[v].z[j]) : 0;
    endtask

    // Start cycle is the first negedge; t counts cycles after it.
    task automatic run_case(input string name, input int sx, input int sy,
                            input int nw, input int nbusy, input bit hold);
        int busy_cnt = 0;
        int wr_cnt   = 0;
        int done_t   = 0;
        bit seen     = 1'b0;
        @(negedge clk);
        chk({name, "_idle_before"}, {bus.busy_o, bus.done_o}, 0);
        bus.size_x_i = 6'(sx);
        bus.size_y_i = 6'(sy);
        bus.start_i  = 1'b1;
        for (int t = 1; t <= 2000 && !seen; t++) begin
            @(negedge clk);
            if (t == 1) bus.start_i = hold;
            if (bus.busy_o) busy_cnt++;
            if (bus.mem_z_we_o) begin
                chk($sformatf("%s_waddr%0d", name, wr_cnt), bus.mem_z_addr_o, wr_cnt);
                chk($sformatf("%s_z%0d", name, wr_cnt), bus.mem_z_data_o, exp_z[wr_cnt & 63]);
                wr_cnt++;
            end
            if (bus.done_o) begin
                seen   = 1'b1;
                done_t = t;
                chk({name, "_busy_at_done"}, bus.busy_o, 0);
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_done_cycle"}, done_t, nbusy + 1);
        chk({name, "_busy_cycles"}, busy_cnt, nbusy);
        chk({name, "_writes"}, wr_cnt, nw);
    endtask

    initial begin
        vecs[0] = '{sx:3, sy:2, nw:4, nbusy:14,
                    x:'{8'd1, 8'd2, 8'd3, 8'd0}, y:'{8'd1, 8'd1, 8'd0, 8'd0},
                    z:'{21'd1, 21'd3, 21'd5, 21'd3, 21'd0, 21'd0, 21'd0}};
        vecs[1] = '{sx:1, sy:3, nw:3, nbusy:9,
                    x:'{8'd7, 8'd0, 8'd0, 8'd0}, y:'{8'd2, 8'd4, 8'd6, 8'd0},
                    z:'{21'd14, 21'd28, 21'd42, 21'd0, 21'd0, 21'd0, 21'd0}};
        vecs[2] = '{sx:2, sy:2, nw:3, nbusy:10,
                    x:'{8'd2, 8'd3, 8'd0, 8'd0}, y:'{8'd4, 8'd5, 8'd0, 8'd0},
                    z:'{21'd8, 21'd22, 21'd15, 21'd0, 21'd0, 21'd0, 21'd0}};
        vecs[3] = '{sx:4, sy:1, nw:4, nbusy:12,
                    x:'{8'd255, 8'd255, 8'd255, 8'd255}, y:'{8'd255, 8'd0, 8'd0, 8'd0},
                    z:'{21'd65025, 21'd65025, 21'd65025, 21'd65025, 21'd0, 21'd0, 21'd0}};
        vecs[4] = '{sx:4, sy:4, nw:7, nbusy:30,
                    x:'{8'd1, 8'd2, 8'd3, 8'd4}, y:'{8'd1, 8'd2, 8'd3, 8'd4},
                    z:'{21'd1, 21'd4, 21'd10, 21'd20, 21'd25, 21'd24, 21'd16}};
        vecs[5] = '{sx:3, sy:0, nw:0, nbusy:0,
                    x:'{8'd1, 8'd2, 8'd3, 8'd0}, y:'{8'd0, 8'd0, 8'd0, 8'd0},
                    z:'{21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0}};
        vecs[6] = '{sx:0, sy:2, nw:0, nbusy:0,
                    x:'{8'd0, 8'd0, 8'd0, 8'd0}, y:'{8'd9, 8'd9, 8'd0, 8'd0},
                    z:'{21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0}};

        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.size_x_i = '0;
        bus.size_y_i = '0;
        load_vec(0);
        repeat (2) @(negedge clk);
        chk("rst_x_addr", bus.mem_x_addr_o, 0);
        chk("rst_y_addr", bus.mem_y_addr_o, 0);
        chk("rst_z_we", bus.mem_z_we_o, 0);
        chk("rst_busy_done", {bus.busy_o, bus.done_o}, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            run_case($sformatf("vec%0d", v), vecs[v].sx, vecs[v].sy,
                     vecs[v].nw, vecs[v].nbusy, 1'b0);
        end

        // Full-size all-0xFF: Z[k] = 65025 * (number of overlapping terms).
        for (int i = 0; i < 32; i++) begin
            xrom[i] = 8'hFF;
            yrom[i] = 8'hFF;
        end
        for (int j = 0; j < 64; j++)
            exp_z[j] = 65025 * (((j < 62 - j) ? j : 62 - j) + 1);
        run_case("full32", 32, 32, 63, 1150, 1'b0);

        // Reset during FETCH of k=2 (cycle 8), then a clean rerun.
        load_vec(0);
        @(negedge clk);
        bus.size_x_i = 6'd3;
        bus.size_y_i = 6'd2;
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", bus.busy_o, 1);
        chk("pre_rst_x_addr", bus.mem_x_addr_o, 1);
        chk("pre_rst_y_addr", bus.mem_y_addr_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x_addr", bus.mem_x_addr_o, 0);
        chk("mid_rst_y_addr", bus.mem_y_addr_o, 0);
        chk("mid_rst_z_addr", bus.mem_z_addr_o, 0);
        chk("mid_rst_z_data", bus.mem_z_data_o, 0);
        chk("mid_rst_flags", {bus.mem_z_we_o, bus.busy_o, bus.done_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("after_rst", 3, 2, 4, 14, 1'b0);

        // start_i held high across two runs.
        run_case("b2b_first", 3, 2, 4, 14, 1'b1);
        run_case("b2b_second", 3, 2, 4, 14, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
